// File: rtl/sc2110_i2c_target_pkg.sv
// Shared types and constants for the sc2110 I2C target (16-bit register address, 8-bit data).
package sc2110_i2c_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DEV_ACK,
        ST_AH,
        ST_AH_ACK,
        ST_AL,
        ST_AL_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RD_MACK,
        ST_WAIT_STOP
    } state_t;

    localparam logic       ACK            = 1'b0;
    localparam logic       NACK           = 1'b1;
    localparam logic [6:0] DEF_SLAVE_ADDR = 7'h30;

endpackage

// File: rtl/sc2110_i2c_target_in_filter.sv
// Pad input conditioning: 2-FF synchronizer, FILT_LEN-sample glitch filter, edge pulses.
module sc2110_i2c_target_in_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_in,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [3:0] LAST = 4'(FILT_LEN - 1);

    logic       r_s1;
    logic       r_s2;
    logic       r_level;
    logic       r_rise;
    logic       r_fall;
    logic [3:0] r_cnt;

    // Idle I2C lines are high, so reset to 1 to avoid a spurious edge at start-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1   <= i_in;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_s2 != r_level) begin
                if (r_cnt == LAST) begin
                    r_level <= r_s2;
                    r_cnt   <= '0;
                    r_rise  <= r_s2;
                    r_fall  <= ~r_s2;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/sc2110_i2c_target.sv
// I2C target: 7-bit device address, 16-bit register pointer (MSB first), 8-bit data with auto-increment.
module sc2110_i2c_target
    import sc2110_i2c_target_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = DEF_SLAVE_ADDR,
    parameter int unsigned FILT_LEN   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;
    logic [7:0] w_byte;

    state_t      r_state;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_shift;
    logic        r_sda_oe;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic        r_we;
    logic        r_re;
    logic        r_load;
    logic        r_busy;
    logic        r_rw;
    logic        r_mack_ok;

    sc2110_i2c_target_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk     (clk),
        .rst     (rst),
        .i_in    (scl_i),
        .o_level (w_scl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    sc2110_i2c_target_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk     (clk),
        .rst     (rst),
        .i_in    (sda_i),
        .o_level (w_sda),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;
    assign w_byte  = {r_shift[6:0], w_sda};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_sda_oe  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_load    <= 1'b0;
            r_busy    <= 1'b0;
            r_rw      <= 1'b0;
            r_mack_ok <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_re   <= 1'b0;
            r_load <= r_re;
            if (w_stop) begin
                r_state   <= ST_IDLE;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
                r_mack_ok <= 1'b0;
            end else if (w_start) begin
                r_state   <= ST_DEV;
                r_bitcnt  <= '0;
                r_sda_oe  <= 1'b0;
                r_mack_ok <= 1'b0;
            end else begin
                case (r_state)
                    ST_DEV: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                if (w_byte[7:1] == SLAVE_ADDR) begin
                                    r_state <= ST_DEV_ACK;
                                    r_busy  <= 1'b1;
                                    r_rw    <= w_byte[0];
                                end else begin
                                    r_state <= ST_WAIT_STOP;
                                end
                            end
                        end
                    end
                    ST_AH, ST_AL, ST_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                if (r_state == ST_AH) begin
                                    r_addr[15:8] <= w_byte;
                                    r_state      <= ST_AH_ACK;
                                end else if (r_state == ST_AL) begin
                                    r_addr[7:0] <= w_byte;
                                    r_state     <= ST_AL_ACK;
                                end else begin
                                    r_we    <= 1'b1;
                                    r_wdata <= w_byte;
                                    r_state <= ST_WDATA_ACK;
                                end
                            end
                        end
                    end
                    // First SCL fall starts the ACK, second fall ends it; r_sda_oe tells them apart.
                    ST_DEV_ACK, ST_AH_ACK, ST_AL_ACK, ST_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                                if (r_state == ST_WDATA_ACK)
                                    r_addr <= r_addr + 16'd1;
                            end else begin
                                r_bitcnt <= '0;
                                if (r_state == ST_DEV_ACK && r_rw) begin
                                    r_re    <= 1'b1;
                                    r_state <= ST_RDATA;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    case (r_state)
                                        ST_DEV_ACK: r_state <= ST_AH;
                                        ST_AH_ACK:  r_state <= ST_AL;
                                        default:    r_state <= ST_WDATA;
                                    endcase
                                end
                            end
                        end
                    end
                    // SDA stays as it is until read data arrives, so ACK low flows straight into bit 7.
                    ST_RDATA: begin
                        if (r_load) begin
                            r_sda_oe <= ~reg_rdata[7];
                            r_shift  <= {reg_rdata[6:0], 1'b0};
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 3'd7) begin
                                r_sda_oe  <= 1'b0;
                                r_mack_ok <= 1'b0;
                                r_state   <= ST_RD_MACK;
                            end else begin
                                r_sda_oe <= ~r_shift[7];
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_bitcnt <= r_bitcnt + 3'd1;
                            end
                        end
                    end
                    ST_RD_MACK: begin
                        if (w_scl_rise) begin
                            if (w_sda == ACK) begin
                                r_mack_ok <= 1'b1;
                                r_addr    <= r_addr + 16'd1;
                            end else begin
                                r_state <= ST_WAIT_STOP;
                                r_busy  <= 1'b0;
                            end
                        end else if (w_scl_fall && r_mack_ok) begin
                            r_mack_ok <= 1'b0;
                            r_re      <= 1'b1;
                            r_bitcnt  <= '0;
                            r_state   <= ST_RDATA;
                        end
                    end
                    ST_IDLE, ST_WAIT_STOP: ;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign sda_oe    = r_sda_oe;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign reg_re    = r_re;
    assign busy      = r_busy;

endmodule
